// File: rtl/apb_cmd_master.sv
// APB3 initiator: turns a valid/ready command stream into single APB transfers
// and returns one response (read data, error, timeout flags) per command.
module apb_cmd_master #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned TO_W           = 16
) (
   input  logic        clk,
   input  logic        reset,
   // Command stream
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic        cmd_write,
   input  logic [31:0] cmd_wdata,
   // Response stream
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic        busy,
   // APB3 initiator
   output logic        psel,
   output logic        penable,
   output logic [31:0] paddr,
   output logic        pwrite,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready,
   input  logic        pslverr
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   // Counter value in the last permitted ACCESS cycle; only used when the timeout is enabled
   localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

   state_e          state;
   logic [TO_W-1:0] to_cnt;

   // Handshake and status outputs are pure state decodes
   always_comb begin
      cmd_ready = (state == StIdle);
      busy      = (state != StIdle);
   end

   // Transfer FSM with registered APB and response outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StIdle;
         to_cnt      <= '0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         paddr       <= '0;
         pwrite      <= 1'b0;
         pwdata      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (cmd_valid) begin
                  paddr   <= cmd_addr;
                  pwrite  <= cmd_write;
                  pwdata  <= cmd_wdata;
                  psel    <= 1'b1;
                  penable <= 1'b0;
                  state   <= StSetup;
               end
            end
            StSetup: begin
               penable <= 1'b1;
               to_cnt  <= '0;
               state   <= StAccess;
            end
            StAccess: begin
               // pready wins over a timeout landing in the same cycle
               if (pready) begin
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_rdata   <= pwrite ? 32'h0 : prdata;
                  rsp_err     <= pslverr;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= StResp;
               end else if ((TIMEOUT_CYCLES != 0) && (to_cnt == ToLast)) begin
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  state       <= StResp;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed self-checking bench for apb_cmd_master (timeout set to 8 cycles).
module tb_apb_cmd_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic        cmd_write;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        busy;
   logic        psel;
   logic        penable;
   logic [31:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int checks   = 0;
   int failures = 0;

   apb_cmd_master #(
      .TIMEOUT_CYCLES(8),
      .TO_W          (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_write  (cmd_write),
      .cmd_wdata  (cmd_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .rsp_timeout(rsp_timeout),
      .busy       (busy),
      .psel       (psel),
      .penable    (penable),
      .paddr      (paddr),
      .pwrite     (pwrite),
      .pwdata     (pwdata),
      .prdata     (prdata),
      .pready     (pready),
      .pslverr    (pslverr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command for one accept edge; leaves the DUT in SETUP
   task automatic start_cmd(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_write = wr;
      cmd_wdata = wdata;
      tick();
      cmd_valid = 1'b0;
      cmd_addr  = 32'hFFFF_FFFF;
      cmd_wdata = 32'hFFFF_FFFF;
   endtask

   // From SETUP: hold pready low for 'waits' ACCESS cycles, then complete
   task automatic run_access(input int waits, input logic [31:0] addr, input logic [31:0] rdata,
                             input logic err);
      pready = 1'b0;
      tick();
      for (int i = 0; i < waits; i++) begin
         check("acc_psel", {31'b0, psel & penable}, 32'h1);
         check("acc_paddr", paddr, addr);
         tick();
      end
      check("acc_last", {31'b0, psel & penable}, 32'h1);
      pready  = 1'b1;
      prdata  = rdata;
      pslverr = err;
      tick();
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'hBAD0_BAD0;
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_drop", {31'b0, rsp_valid}, 32'h0);
      check("back_idle", {31'b0, cmd_ready}, 32'h1);
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_write = 1'b0;
      cmd_wdata = '0;
      rsp_ready = 1'b0;
      prdata    = 32'hBAD0_BAD0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      tick();
      tick();
      check("rst_outs", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, busy}, 32'h0);
      check("rst_paddr", paddr, 32'h0);
      check("rst_pwdata", pwdata, 32'h0);
      check("rst_rdata", rsp_rdata, 32'h0);
      reset = 1'b0;
      tick();
      check("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);

      // 1: zero-wait write
      cmd_valid = 1'b1;
      cmd_addr  = 32'h04;
      cmd_write = 1'b1;
      cmd_wdata = 32'hA5;
      pready    = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check("w_c1_sel_en", {30'b0, psel, penable}, 32'h2);
      check("w_c1_busy", {30'b0, busy, cmd_ready}, 32'h2);
      check("w_paddr", paddr, 32'h04);
      tick();
      check("w_c2_sel_en", {30'b0, psel, penable}, 32'h3);
      check("w_c2_rspv", {31'b0, rsp_valid}, 32'h0);
      tick();
      pready = 1'b0;
      check("w_c3_rspv", {31'b0, rsp_valid}, 32'h1);
      check("w_c3_flags", {29'b0, rsp_err, rsp_timeout, psel}, 32'h0);
      check("w_rdata", rsp_rdata, 32'h0);
      check("w_pwrite", {31'b0, pwrite}, 32'h1);
      check("w_pwdata", pwdata, 32'h0000_00A5);
      consume();

      // 2: zero-wait read
      start_cmd(32'h10, 1'b0, 32'h0);
      run_access(0, 32'h10, 32'h0000_005A, 1'b0);
      check("r_rdata", rsp_rdata, 32'h0000_005A);
      check("r_flags", {30'b0, rsp_err, rsp_timeout}, 32'h0);
      consume();

      // 3: write with 3 wait states and slave error; prdata must not leak into rsp_rdata
      start_cmd(32'h20, 1'b1, 32'h1234_5678);
      run_access(3, 32'h20, 32'hDEAD_BEEF, 1'b1);
      check("ws_pwdata", pwdata, 32'h1234_5678);
      check("ws_flags", {30'b0, rsp_err, rsp_timeout}, 32'h2);
      check("ws_rdata", rsp_rdata, 32'h0);
      consume();

      // 4: timeout after exactly 8 ACCESS cycles
      start_cmd(32'h30, 1'b0, 32'h0);
      prdata = 32'h7777_7777;
      pready = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         check("to_access", {30'b0, psel, penable}, 32'h3);
         tick();
      end
      check("to_psel", {31'b0, psel}, 32'h0);
      check("to_flags", {29'b0, rsp_valid, rsp_err, rsp_timeout}, 32'h7);
      check("to_rdata", rsp_rdata, 32'h0);
      consume();

      // 4b: pready on the 8th ACCESS cycle completes normally
      start_cmd(32'h34, 1'b0, 32'h0);
      run_access(7, 32'h34, 32'h0000_0C0D, 1'b0);
      check("to8_flags", {29'b0, rsp_valid, rsp_err, rsp_timeout}, 32'h4);
      check("to8_rdata", rsp_rdata, 32'h0000_0C0D);
      consume();

      // 5: response backpressure with a pending command
      start_cmd(32'h40, 1'b0, 32'h0);
      run_access(0, 32'h40, 32'h0000_1234, 1'b0);
      cmd_valid = 1'b1;
      cmd_addr  = 32'h44;
      cmd_write = 1'b1;
      cmd_wdata = 32'h99;
      for (int i = 0; i < 5; i++) begin
         check("bp_rdata", rsp_rdata, 32'h0000_1234);
         check("bp_state", {28'b0, rsp_valid, cmd_ready, busy, psel}, 32'hA);
         check("bp_paddr", paddr, 32'h40);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp_release", {30'b0, rsp_valid, cmd_ready}, 32'h1);
      tick();
      cmd_valid = 1'b0;
      check("bp_next_paddr", paddr, 32'h44);
      check("bp_next_psel", {31'b0, psel}, 32'h1);
      run_access(0, 32'h44, 32'h0, 1'b0);
      check("bp_next_rsp", {31'b0, rsp_valid}, 32'h1);
      consume();

      // 6: reset during ACCESS discards the transfer
      start_cmd(32'h50, 1'b0, 32'h0);
      pready = 1'b0;
      tick();
      check("mr_in_access", {30'b0, psel, penable}, 32'h3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mr_outs", {28'b0, psel, penable, rsp_valid, busy}, 32'h0);
      check("mr_cmd_ready", {31'b0, cmd_ready}, 32'h1);
      check("mr_paddr", paddr, 32'h0);
      pready    = 1'b1;
      rsp_ready = 1'b1;
      prdata    = 32'h5555_5555;
      for (int i = 0; i < 4; i++) begin
         check("mr_no_stale", {29'b0, rsp_valid, psel, busy}, 32'h0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
